top_prod_accum_rescale: RTL

Downstream consumer of the 32×30-bit unsigned multiplier (62-bit product). Accumulates a stream of products into groups delimited by a `last` flag, then rounds, shifts and saturates each group sum to a 32-bit result. Valid/ready handshake on both sides; one registered result per group, one cycle after the last beat.

---
 rtl/top_prod_accum_rescale_pkg.sv | 31 +++
 rtl/top_prod_accum_rescale_if.sv | 28 ++
 rtl/top_prod_accum_rescale_round_sat.sv | 43 ++++
 rtl/top_prod_accum_rescale.sv | 106 ++++++++++
 4 files changed

// File: rtl/top_prod_accum_rescale_pkg.sv
// Shared widths, FSM encoding and datapath types for the product
// accumulate / rescale block.
package top_rescale_pkg;

  localparam int PROD_WIDTH  = 62;
  localparam int ACC_WIDTH   = 72;
  localparam int OUT_WIDTH   = 32;
  localparam int SHIFT_WIDTH = 6;
  localparam int CNT_WIDTH   = 16;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  typedef logic [ACC_WIDTH-1:0]   acc_t;
  typedef logic [ACC_WIDTH:0]     sum_t;
  typedef logic [OUT_WIDTH-1:0]   out_t;
  typedef logic [PROD_WIDTH-1:0]  prod_t;
  typedef logic [SHIFT_WIDTH-1:0] shift_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t cnt_inc(input cnt_t c);
    cnt_t r;
    r = c;
    if (c != {CNT_WIDTH{1'b1}}) r = c + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/top_prod_accum_rescale_if.sv
// Stream bundle: product beats in, rescaled group results out.
interface top_prod_accum_rescale_if;
  import top_rescale_pkg::*;

  logic   in_valid;
  logic   in_ready;
  prod_t  in_prod;
  logic   in_last;
  shift_t cfg_shift;
  logic   out_valid;
  logic   out_ready;
  out_t   out_data;
  logic   out_sat;
  cnt_t   out_count;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_prod, in_last, cfg_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  // Accumulator block side.
  modport slave (
    input  in_valid, in_prod, in_last, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );

endinterface

// File: rtl/top_prod_accum_rescale_round_sat.sv
// Combinational round-half-up, right shift and clamp of a group sum
// down to the output width.
module top_round_sat
  import top_rescale_pkg::*;
(
  input  sum_t   sum,
  input  logic   ovf,
  input  shift_t shift,
  output out_t   data,
  output logic   sat
);

  localparam int RW = ACC_WIDTH + 2;

  typedef logic [RW-1:0] rnd_t;

  // Add half an output LSB before shifting; one extra bit keeps the
  // rounding add itself from wrapping.
  function automatic rnd_t round_shift(input sum_t s, input shift_t sh);
    rnd_t half;
    rnd_t ext;
    half = '0;
    if (sh != '0) half = rnd_t'(1) << (sh - 1'b1);
    ext = {1'b0, s} + half;
    return ext >> sh;
  endfunction

  // Anything that cannot be represented, including a lost accumulator
  // carry, is reported as full scale.
  function automatic logic needs_sat(input rnd_t r, input logic carry);
    return carry || (r[RW-1:OUT_WIDTH] != '0);
  endfunction

  rnd_t rounded;

  // Round, shift and clamp.
  always_comb begin
    rounded = round_shift(sum, shift);
    sat     = needs_sat(rounded, ovf || sum[ACC_WIDTH]);
    data    = sat ? {OUT_WIDTH{1'b1}} : rounded[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/top_prod_accum_rescale.sv
// Accumulates unsigned multiplier products into last-delimited groups
// and emits one rounded, shifted, saturated result per group.
module top_prod_accum_rescale
  import top_rescale_pkg::*;
(
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  top_prod_accum_rescale_if.slave  bus
);

  state_t state_q;
  state_t state_d;

  acc_t   acc_q;
  cnt_t   cnt_q;
  shift_t shift_q;
  logic   ovf_q;

  logic   out_valid_q;
  out_t   out_data_q;
  logic   out_sat_q;
  cnt_t   out_count_q;

  logic   accept;
  logic   emit;
  logic   first;
  acc_t   base;
  sum_t   sum_p0;
  shift_t shift_p0;
  logic   ovf_p0;
  cnt_t   cnt_p0;
  out_t   rs_data;
  logic   rs_sat;

  // Input stalls as a whole whenever a result is held and not drained.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign emit          = accept && bus.in_last;

  // The first beat of a group starts from zero and takes the live shift.
  assign first    = (state_q == ST_IDLE);
  assign base     = first ? '0 : acc_q;
  assign sum_p0   = {1'b0, base} + {1'b0, {(ACC_WIDTH-PROD_WIDTH){1'b0}}, bus.in_prod};
  assign shift_p0 = first ? bus.cfg_shift : shift_q;
  assign ovf_p0   = first ? 1'b0 : ovf_q;
  assign cnt_p0   = first ? cnt_t'(1) : cnt_inc(cnt_q);

  top_round_sat u_round_sat (
    .sum   (sum_p0),
    .ovf   (ovf_p0),
    .shift (shift_p0),
    .data  (rs_data),
    .sat   (rs_sat)
  );

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state: a closing beat always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = bus.in_last ? ST_IDLE : ST_ACCUM;
  end

  // Partial-group state; only updated by non-closing beats.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept && !bus.in_last) begin
      acc_q   <= sum_p0[ACC_WIDTH-1:0];
      cnt_q   <= cnt_p0;
      shift_q <= shift_p0;
      ovf_q   <= ovf_p0 || sum_p0[ACC_WIDTH];
    end
  end

  // ---- stage p1: registered result, held until drained ----
  // A new emit overrides a simultaneous drain so back-to-back results flow.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rs_data;
      out_sat_q   <= rs_sat;
      out_count_q <= cnt_p0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_count = out_count_q;

endmodule
